// File: rtl/rf_wport_scheduler_if.sv
// Bundle of decode, writeback, long-unit and regfile write-port signals
// around the write-port scheduler.
interface rf_wport_scheduler_if #(
  parameter int CNT_W = 2
);
  logic [4:0]       dec_addr_a;
  logic [4:0]       dec_addr_b;
  logic [4:0]       dec_rd;
  logic             stall;
  logic             issue_en;
  logic             issue_long;
  logic             wb_en;
  logic [4:0]       wb_addr;
  logic [31:0]      wb_data;
  logic             lu_valid;
  logic [4:0]       lu_addr;
  logic [31:0]      lu_data;
  logic             lu_ready;
  logic             en_w;
  logic [4:0]       addr_w;
  logic [31:0]      data_w;
  logic [CNT_W-1:0] fifo_count;

  modport master (
    output dec_addr_a, dec_addr_b, dec_rd, issue_en, issue_long,
    output wb_en, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
    input  stall, lu_ready, en_w, addr_w, data_w, fifo_count
  );

  modport slave (
    input  dec_addr_a, dec_addr_b, dec_rd, issue_en, issue_long,
    input  wb_en, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
    output stall, lu_ready, en_w, addr_w, data_w, fifo_count
  );
endinterface

// File: rtl/rf_wport_scheduler.sv
// Arbitrates the single regfile write port between pipeline writeback and a
// queued long-latency unit, and tracks outstanding long results for hazard stalls.
module rf_wport_scheduler #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input logic                 clk,
  input logic                 rst,
  rf_wport_scheduler_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [4:0]       fifo_addr_q [DEPTH];
  logic [31:0]      fifo_data_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      busy_q, busy_d;
  logic             empty;
  logic             ready;
  logic             push;
  logic             drain;

  always_comb begin
    empty = (count_q == '0);
    ready = (count_q != CNT_W'(DEPTH));
    push  = bus.lu_valid && ready;
    drain = !bus.wb_en && !empty;
  end

  // Writeback always owns the port; the FIFO head only gets idle cycles.
  always_comb begin
    bus.en_w   = 1'b0;
    bus.addr_w = 5'd0;
    bus.data_w = 32'd0;
    if (bus.wb_en) begin
      bus.en_w   = 1'b1;
      bus.addr_w = bus.wb_addr;
      bus.data_w = bus.wb_data;
    end else if (!empty) begin
      bus.en_w   = 1'b1;
      bus.addr_w = fifo_addr_q[head_q];
      bus.data_w = fifo_data_q[head_q];
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain) head_d = head_q + PTR_W'(1);
    if (push)  tail_d = tail_q + PTR_W'(1);
    case ({push, drain})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Clear is applied before set so a same-cycle reissue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (drain) busy_d[fifo_addr_q[head_q]] = 1'b0;
    if (bus.issue_en && bus.issue_long && (bus.dec_rd != 5'd0))
      busy_d[bus.dec_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    bus.stall      = busy_q[bus.dec_addr_a] | busy_q[bus.dec_addr_b] | busy_q[bus.dec_rd];
    bus.lu_ready   = ready;
    bus.fifo_count = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[tail_q] <= bus.lu_addr;
      fifo_data_q[tail_q] <= bus.lu_data;
    end
  end
endmodule
